// File: rtl/trans_dispatcher_if.sv
// Handshake bundle between the sources, the dispatcher and the validator.
// The master modport is the dispatcher's view; slave is the surrounding environment.
interface trans_dispatcher_if #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DATA_W  = 128
);
    logic [NUM_SRC*DATA_W-1:0] src_data_i;
    logic [NUM_SRC-1:0]        src_valid_i;
    logic [NUM_SRC-1:0]        src_ready_o;
    logic [DATA_W-1:0]         val_data_o;
    logic                      val_valid_o;
    logic                      val_done_i;

    modport master (
        input  src_data_i,
        input  src_valid_i,
        input  val_done_i,
        output src_ready_o,
        output val_data_o,
        output val_valid_o
    );

    modport slave (
        output src_data_i,
        output src_valid_i,
        output val_done_i,
        input  src_ready_o,
        input  val_data_o,
        input  val_valid_o
    );
endinterface

// File: rtl/trans_dispatcher.sv
// Round-robin front end for the transaction validator: one holding slot per source,
// one transaction outstanding at a time, released by done or by a watchdog.
module trans_dispatcher #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned TIMEOUT = 40000
) (
    input  logic                       clk,
    input  logic                       rst,
    trans_dispatcher_if.master         bus,
    output logic                       busy_o,
    output logic [$clog2(NUM_SRC)-1:0] last_src_o,
    output logic [31:0]                dispatch_cnt_o,
    output logic [15:0]                timeout_cnt_o
);
    localparam int unsigned IdxW   = $clog2(NUM_SRC);
    localparam int unsigned TimerW = $clog2(TIMEOUT);

    typedef enum logic [0:0] {StIdle, StWaitDone} state_e;

    state_e             state_q;
    logic [DATA_W-1:0]  hold_data_q [NUM_SRC];
    logic [NUM_SRC-1:0] hold_v_q;
    logic [IdxW-1:0]    rr_q;
    logic [DATA_W-1:0]  val_data_q;
    logic               val_valid_q;
    logic [TimerW-1:0]  timer_q;
    logic [31:0]        disp_cnt_q;
    logic [15:0]        tout_cnt_q;

    logic [IdxW-1:0]    grant;
    logic               grant_vld;
    logic [IdxW:0]      cand_sum;

    // Search rr+1, rr+2, ... wrapping; rr itself is visited last (offset NUM_SRC).
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        cand_sum  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand_sum = {1'b0, rr_q} + (IdxW + 1)'(k);
            if (cand_sum >= (IdxW + 1)'(NUM_SRC)) begin
                cand_sum = cand_sum - (IdxW + 1)'(NUM_SRC);
            end
            if (!grant_vld && hold_v_q[cand_sum[IdxW-1:0]]) begin
                grant     = cand_sum[IdxW-1:0];
                grant_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            hold_v_q    <= '0;
            rr_q        <= '0;
            val_data_q  <= '0;
            val_valid_q <= 1'b0;
            timer_q     <= '0;
            disp_cnt_q  <= '0;
            tout_cnt_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (bus.src_valid_i[i] && !hold_v_q[i]) begin
                    hold_data_q[i] <= bus.src_data_i[i*DATA_W +: DATA_W];
                    hold_v_q[i]    <= 1'b1;
                end
            end
            val_valid_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    // The granted slot was full, so no capture above can collide with this clear.
                    if (grant_vld) begin
                        val_data_q      <= hold_data_q[grant];
                        val_valid_q     <= 1'b1;
                        hold_v_q[grant] <= 1'b0;
                        rr_q            <= grant;
                        disp_cnt_q      <= disp_cnt_q + 32'd1;
                        timer_q         <= '0;
                        state_q         <= StWaitDone;
                    end
                end
                StWaitDone: begin
                    timer_q <= timer_q + TimerW'(1);
                    if (bus.val_done_i) begin
                        state_q <= StIdle;
                    end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
                        if (tout_cnt_q != 16'hFFFF) begin
                            tout_cnt_q <= tout_cnt_q + 16'd1;
                        end
                        state_q <= StIdle;
                    end
                end
            endcase
        end
    end

    assign bus.src_ready_o = ~hold_v_q;
    assign bus.val_data_o  = val_data_q;
    assign bus.val_valid_o = val_valid_q;
    assign busy_o          = (state_q == StWaitDone);
    assign last_src_o      = rr_q;
    assign dispatch_cnt_o  = disp_cnt_q;
    assign timeout_cnt_o   = tout_cnt_q;

    a_strobe_in_wait: assert property (@(posedge clk) disable iff (rst)
        val_valid_q |-> (state_q == StWaitDone));
    a_single_strobe: assert property (@(posedge clk) disable iff (rst)
        val_valid_q |=> !val_valid_q);

endmodule

// File: tb/tb_trans_dispatcher.sv
// Randomised scoreboard bench for trans_dispatcher against a transaction-level reference model.
module tb_trans_dispatcher;
    localparam int unsigned NSRC = 4;
    localparam int unsigned DW   = 128;
    localparam int unsigned TMO  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trans_dispatcher_if #(.NUM_SRC(NSRC), .DATA_W(DW)) bus ();

    logic        busy;
    logic [1:0]  last_src;
    logic [31:0] disp_cnt;
    logic [15:0] tout_cnt;

    trans_dispatcher #(.NUM_SRC(NSRC), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .busy_o         (busy),
        .last_src_o     (last_src),
        .dispatch_cnt_o (disp_cnt),
        .timeout_cnt_o  (tout_cnt)
    );

    typedef struct {
        int              src;
        logic [DW-1:0]   data;
        int unsigned     cnt;
    } issue_t;

    typedef struct {
        string         name;
        logic [DW-1:0] act;
        logic [DW-1:0] exp;
    } dir_t;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: slots, outstanding transaction, counters.
    bit            m_slot_v [NSRC];
    logic [DW-1:0] m_slot_d [NSRC];
    bit            m_busy;
    int            m_issue_cyc;
    int            m_last;
    int unsigned   m_disp;
    int            m_tout;
    bit            m_strobe;
    logic [DW-1:0] m_data;
    int            cyc     = 0;
    bit            started = 0;

    issue_t        sb_q [$];
    dir_t          dir_q [$];
    logic [DW-1:0] src_q [NSRC][$];
    int            issued_log [$];
    int            busy_cycles = 0;

    int  done_delay = 0;
    bit  done_rand  = 0;
    bit  spurious   = 0;

    task automatic model_edge();
        int g;
        bit cap [NSRC];
        cyc++;
        started  = 1;
        m_strobe = 0;
        if (rst) begin
            for (int i = 0; i < NSRC; i++) m_slot_v[i] = 0;
            m_busy = 0; m_last = 0; m_disp = 0; m_tout = 0; m_data = '0;
            return;
        end
        g = -1;
        if (!m_busy) begin
            for (int off = 1; off <= NSRC; off++) begin
                int j;
                j = (m_last + off) % NSRC;
                if (g < 0 && m_slot_v[j]) g = j;
            end
        end
        for (int i = 0; i < NSRC; i++) cap[i] = bus.src_valid_i[i] && !m_slot_v[i];
        for (int i = 0; i < NSRC; i++) begin
            if (cap[i]) begin
                m_slot_v[i] = 1;
                m_slot_d[i] = bus.src_data_i[i*DW +: DW];
                void'(src_q[i].pop_front());
            end
        end
        if (g >= 0) begin
            m_slot_v[g] = 0;
            m_data      = m_slot_d[g];
            m_strobe    = 1;
            m_busy      = 1;
            m_issue_cyc = cyc;
            m_last      = g;
            m_disp++;
            sb_q.push_back('{g, m_data, m_disp});
        end else if (m_busy) begin
            if (bus.val_done_i) begin
                m_busy = 0;
            end else if (cyc - m_issue_cyc == TMO) begin
                m_busy = 0;
                if (m_tout < 65535) m_tout++;
            end
        end
    endtask

    task automatic drive();
        logic [NSRC*DW-1:0] d;
        logic [NSRC-1:0]    v;
        d = '0;
        v = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_q[i].size() > 0) begin
                v[i]          = 1'b1;
                d[i*DW +: DW] = src_q[i][0];
            end
        end
        bus.src_valid_i = v;
        bus.src_data_i  = d;
        bus.val_done_i  = (m_busy && done_delay > 0 && (cyc + 1 - m_issue_cyc) == done_delay)
                        || (!m_busy && spurious)
                        || (done_rand && $urandom_range(0, 15) == 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        if (m_strobe && done_rand) done_delay = $urandom_range(1, 20);
        #1;
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic expect_eq(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        dir_q.push_back('{name, act, exp});
    endtask

    function automatic bit all_idle();
        bit r;
        r = !m_busy;
        for (int i = 0; i < NSRC; i++) r = r && src_q[i].size() == 0 && !m_slot_v[i];
        return r;
    endfunction

    task automatic drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while (!all_idle() && n < max_cyc) begin
            step();
            n++;
        end
        expect_eq(name, DW'(all_idle()), DW'(1));
        run(2);
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [NSRC-1:0] mon_rdy;
    issue_t          mon_e;
    dir_t            mon_d;

    // Monitor: per-cycle output checks, scoreboard pops on each strobe, directed expectations.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < NSRC; i++) mon_rdy[i] = !m_slot_v[i];
            if (busy) busy_cycles++;
            check("busy", DW'(busy), DW'(m_busy));
            check("src_ready", DW'(bus.src_ready_o), DW'(mon_rdy));
            check("val_valid", DW'(bus.val_valid_o), DW'(m_strobe));
            check("val_data", bus.val_data_o, m_data);
            check("last_src", DW'(last_src), DW'(m_last));
            check("dispatch_cnt", DW'(disp_cnt), DW'(m_disp));
            check("timeout_cnt", DW'(tout_cnt), DW'(m_tout));
            if (bus.val_valid_o) begin
                issued_log.push_back(int'(last_src));
                if (sb_q.size() == 0) begin
                    check("unexpected_issue", DW'(1), DW'(0));
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_data", bus.val_data_o, mon_e.data);
                    check("sb_src", DW'(last_src), DW'(mon_e.src));
                    check("sb_cnt", DW'(disp_cnt), DW'(mon_e.cnt));
                end
            end else if (sb_q.size() > 0) begin
                check("missing_issue", DW'(0), DW'(1));
                void'(sb_q.pop_front());
            end
            while (dir_q.size() > 0) begin
                mon_d = dir_q.pop_front();
                check(mon_d.name, mon_d.act, mon_d.exp);
            end
        end
    end

    int b0;
    int l0;
    int cnt_src [NSRC];

    initial begin
        rst = 1'b1;
        bus.src_valid_i = '0;
        bus.src_data_i  = '0;
        bus.val_done_i  = 1'b0;
        run(3);
        rst = 1'b0;
        expect_eq("reset_dispatch", DW'(disp_cnt), DW'(0));
        expect_eq("reset_ready", DW'(bus.src_ready_o), DW'(4'hF));
        run(2);

        // Single transaction, done 5 cycles after issue.
        b0 = busy_cycles;
        done_delay = 5;
        src_q[0].push_back(128'h0011_2233_4455_6677_8899_AABB_CCDD_EEA5);
        drive();
        run(20);
        expect_eq("t1_dispatch", DW'(disp_cnt), DW'(1));
        expect_eq("t1_busy_cycles", DW'(busy_cycles - b0), DW'(5));
        expect_eq("t1_data", bus.val_data_o, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEA5);

        // All sources loaded; round-robin order and fairness.
        l0 = issued_log.size();
        done_delay = 2;
        for (int i = 0; i < NSRC; i++)
            for (int k = 0; k < 5; k++) src_q[i].push_back({$urandom(), $urandom(), $urandom(), $urandom()});
        drive();
        drain("t2_drain", 300);
        expect_eq("t2_issues", DW'(issued_log.size() - l0), DW'(20));
        expect_eq("t2_order", {issued_log[l0], issued_log[l0+1], issued_log[l0+2], issued_log[l0+3]},
                  {32'd1, 32'd2, 32'd3, 32'd0});
        for (int i = 0; i < NSRC; i++) cnt_src[i] = 0;
        for (int k = l0; k < issued_log.size(); k++) cnt_src[issued_log[k]]++;
        for (int i = 0; i < NSRC; i++) expect_eq("t2_fair", DW'(cnt_src[i]), DW'(5));

        // Back-pressure on source 2 while the validator is busy.
        l0 = issued_log.size();
        done_delay = 6;
        src_q[0].push_back(128'hCAFE_0000);
        drive();
        run(2);
        src_q[2].push_back(128'hB0B0_0001);
        src_q[2].push_back(128'hB0B0_0002);
        drive();
        run(3);
        expect_eq("t3_stall", DW'(bus.src_ready_o[2]), DW'(0));
        drain("t3_drain", 100);
        expect_eq("t3_order", {issued_log[l0], issued_log[l0+1], issued_log[l0+2]},
                  {32'd0, 32'd2, 32'd2});

        // Watchdog expiry, then a late done in idle.
        b0 = busy_cycles;
        done_delay = 0;
        src_q[1].push_back(128'h7777);
        drive();
        run(25);
        expect_eq("t4_timeout", DW'(tout_cnt), DW'(1));
        expect_eq("t4_busy_cycles", DW'(busy_cycles - b0), DW'(TMO));
        spurious = 1;
        drive();
        run(1);
        spurious = 0;
        run(3);
        expect_eq("t4_late_done", DW'(tout_cnt), DW'(1));
        expect_eq("t4_no_issue", DW'(busy), DW'(0));

        // Done on the final watchdog cycle counts as done.
        done_delay = TMO;
        src_q[3].push_back(128'h3333);
        drive();
        run(25);
        expect_eq("t5_coincident", DW'(tout_cnt), DW'(1));
        expect_eq("t5_dispatch", DW'(disp_cnt), DW'(26));

        // Reset while waiting with two held transactions.
        done_delay = 0;
        src_q[0].push_back(128'hA0);
        src_q[1].push_back(128'hA1);
        src_q[2].push_back(128'hA2);
        drive();
        run(4);
        rst = 1'b1;
        for (int i = 0; i < NSRC; i++) src_q[i].delete();
        drive();
        run(1);
        rst = 1'b0;
        expect_eq("t6_busy", DW'(busy), DW'(0));
        expect_eq("t6_dispatch", DW'(disp_cnt), DW'(0));
        expect_eq("t6_ready", DW'(bus.src_ready_o), DW'(4'hF));
        run(10);
        expect_eq("t6_quiet", DW'(disp_cnt), DW'(0));

        // Random traffic with random validator latency and stray dones.
        done_rand = 1;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NSRC; i++)
                if ($urandom_range(0, 3) == 0 && src_q[i].size() < 3)
                    src_q[i].push_back({$urandom(), $urandom(), $urandom(), $urandom()});
            drive();
            step();
        end
        done_rand  = 0;
        done_delay = 3;
        drive();
        drain("rand_drain", 500);
        expect_eq("sb_empty", DW'(sb_q.size()), DW'(0));
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
